// File: rtl/pgtbl_ctrl.sv
// pgtbl_ctrl: page table SRAM controller arbitrating 68000 bus accesses and MMU lookups
// over a single async SRAM with configurable strobe wait states.
module pgtbl_ctrl #(
    parameter int SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  addr,
    input  logic        lds,
    input  logic        uds,
    input  logic        write,
    inout  wire  [15:0] d,
    input  logic        wprot,
    output logic        dtack,
    output logic        berr,
    input  logic        lk_req,
    input  logic [7:0]  lk_idx,
    output logic        lk_ack,
    output logic [15:0] lk_data,
    output logic [7:0]  sram_a,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);
    typedef enum logic [2:0] {IDLE, LK_RD, CPU_RD, CPU_WR_SU, CPU_WR, CPU_WR_HD, CPU_DONE, CPU_ERR} state_t;
    localparam logic [2:0] LAST = 3'(SRAM_WAIT);
    state_t state, nxt;
    logic [2:0] cnt;
    logic prio, rd, cpu_req, lk_pend, lk_win, cpu_win, last, rd_ph, wr_ph;
    logic [7:0] aq;
    logic [15:0] dq;
    logic [1:0] ln;
    assign cpu_req = enable & ~(lds & uds);
    // the requester still sees lk_req high during the ack cycle; ignore it there
    assign lk_pend = lk_req & ~lk_ack;
    assign lk_win = lk_pend & (~cpu_req | ~prio);
    assign cpu_win = cpu_req & ~lk_win;
    assign last = cnt == LAST;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt <= 3'd0;
        end else begin
            state <= nxt;
            cnt <= (nxt == state) ? cnt + 3'd1 : 3'd0;
        end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:               nxt = lk_win ? LK_RD : !cpu_win ? IDLE : !write ? CPU_RD : wprot ? CPU_ERR : CPU_WR_SU;
            LK_RD:              nxt = last ? IDLE : LK_RD;
            CPU_RD:             nxt = !last ? CPU_RD : enable ? CPU_DONE : IDLE;
            CPU_WR_SU:          nxt = CPU_WR;
            CPU_WR:             nxt = last ? CPU_WR_HD : CPU_WR;
            CPU_WR_HD:          nxt = enable ? CPU_DONE : IDLE;
            CPU_DONE, CPU_ERR:  nxt = enable ? state : IDLE;
            default:            nxt = IDLE;
        endcase
    end
    // address, write data and lanes are latched at grant so an aborted cycle still writes cleanly
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prio <= 1'b0;
            rd <= 1'b0;
            aq <= 8'd0;
            dq <= 16'd0;
            ln <= 2'b11;
            lk_ack <= 1'b0;
            lk_data <= 16'd0;
        end else begin
            lk_ack <= state == LK_RD && last;
            if (state == LK_RD && last) lk_data <= sram_din;
            if (state == CPU_RD && last) dq <= sram_din;
            if (state == IDLE && (lk_win || cpu_win)) begin
                aq <= lk_win ? lk_idx : addr;
                dq <= d;
                ln <= {uds, lds};
                rd <= ~write;
            end
            if (state == IDLE && (lk_win || (cpu_win && !(write && wprot)))) prio <= lk_win;
        end
    always_comb begin
        rd_ph = state == LK_RD || state == CPU_RD;
        wr_ph = state == CPU_WR_SU || state == CPU_WR || state == CPU_WR_HD;
        sram_ce_n = ~(rd_ph | wr_ph);
        sram_oe_n = ~rd_ph;
        sram_we_n = state != CPU_WR;
        sram_lb_n = rd_ph ? 1'b0 : wr_ph ? ln[0] : 1'b1;
        sram_ub_n = rd_ph ? 1'b0 : wr_ph ? ln[1] : 1'b1;
        sram_a = (rd_ph | wr_ph) ? aq : 8'd0;
        sram_dout = wr_ph ? dq : 16'd0;
        dtack = ~(state == CPU_DONE && enable);
        berr = ~(state == CPU_ERR && enable);
    end
    assign d = (state == CPU_DONE && rd && enable) ? dq : 16'hzzzz;
endmodule

// File: tb/tb_pgtbl_ctrl.sv
// tb_pgtbl_ctrl: randomized self-checking bench for pgtbl_ctrl against a memory/priority
// reference model and an async SRAM model.
module tb_pgtbl_ctrl;
    localparam int W = 1;
    localparam int N = W + 1;
    logic clk = 0, reset_n = 0, enable = 0, lds = 1, uds = 1, write = 0, wprot = 0, lk_req = 0;
    logic [7:0] addr = 0, lk_idx = 0;
    wire [15:0] d;
    logic [15:0] d_drv = 0;
    logic d_en = 0;
    logic dtack, berr, lk_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic [15:0] lk_data, sram_din, sram_dout;
    logic [7:0] sram_a;
    logic [15:0] mem [256] = '{default: 16'h0};
    logic [15:0] ref_mem [256];
    int n_chk = 0, n_fail = 0;
    bit m_prio = 0, clash = 0;

    pgtbl_ctrl #(.SRAM_WAIT(W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .addr(addr), .lds(lds), .uds(uds),
        .write(write), .d(d), .wprot(wprot), .dtack(dtack), .berr(berr), .lk_req(lk_req),
        .lk_idx(lk_idx), .lk_ack(lk_ack), .lk_data(lk_data), .sram_a(sram_a), .sram_din(sram_din),
        .sram_dout(sram_dout), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;
    assign d = d_en ? d_drv : 16'hzzzz;
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'h0;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_a][7:0] = sram_dout[7:0];
            if (!sram_ub_n) mem[sram_a][15:8] = sram_dout[15:8];
        end
    always @(negedge clk) if (!sram_oe_n && !sram_we_n) clash = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_write(input logic [7:0] a, input logic [15:0] wd, input logic l, input logic u);
        if (!l) ref_mem[a][7:0] = wd[7:0];
        if (!u) ref_mem[a][15:8] = wd[15:8];
    endtask

    task automatic cpu_acc(input bit wr, input logic [7:0] a, input logic [15:0] wd, input logic l,
                           input logic u, output logic [15:0] rdat, output int wec, output bit ack,
                           output bit err, output bit ce_seen, output logic [1:0] lanes);
        rdat = 0; wec = 0; ack = 0; err = 0; ce_seen = 0; lanes = 2'b11;
        enable = 1; addr = a; write = wr; lds = l; uds = u; d_drv = wd; d_en = wr;
        for (int i = 0; i < 30 && !ack && !err; i++) begin
            @(negedge clk);
            if (!sram_ce_n) ce_seen = 1;
            if (!sram_we_n) begin wec++; lanes = {sram_ub_n, sram_lb_n}; end
            if (!dtack) begin ack = 1; rdat = d; end
            if (!berr) err = 1;
        end
        enable = 0; lds = 1; uds = 1; d_en = 0;
        #1;
        chk("dtack_drop", 32'(dtack), 1);
        chk("berr_drop", 32'(berr), 1);
        @(negedge clk);
        if (!err) m_prio = 0;
        if (ack && wr) ref_write(a, wd, l, u);
    endtask

    task automatic lookup(input logic [7:0] idx, output int lat, output int acks);
        lat = 0; acks = 0; lk_req = 1; lk_idx = idx;
        for (int i = 1; i <= 20 && acks == 0; i++) begin
            @(negedge clk);
            if (lk_ack) begin acks = 1; lat = i; end
        end
        lk_req = 0; m_prio = 1;
        repeat (4) begin @(negedge clk); if (lk_ack) acks++; end
    endtask

    task automatic contest(input logic [7:0] la, input logic [7:0] ca);
        bit lk_first, got_lk, got_cpu;
        logic [15:0] rdat;
        lk_first = !m_prio; got_lk = 0; got_cpu = 0; rdat = 0;
        lk_req = 1; lk_idx = la; enable = 1; addr = ca; write = 0; lds = 0; uds = 0;
        @(negedge clk);
        chk("contest_oe", 32'(sram_oe_n), 0);
        chk("contest_winner", 32'(sram_a), 32'(lk_first ? la : ca));
        for (int i = 0; i < 40 && !(got_lk && got_cpu); i++) begin
            @(negedge clk);
            if (lk_ack && !got_lk) begin got_lk = 1; lk_req = 0; end
            if (!dtack && !got_cpu) begin got_cpu = 1; rdat = d; enable = 0; lds = 1; uds = 1; end
        end
        chk("contest_done", 32'(got_lk && got_cpu), 1);
        chk("contest_lk_data", 32'(lk_data), 32'(ref_mem[la]));
        chk("contest_rd", 32'(rdat), 32'(ref_mem[ca]));
        m_prio = !lk_first;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rdat, held;
        logic [1:0] lanes;
        int wec, lat, acks;
        bit ack, err, ce, seen;
        foreach (ref_mem[i]) ref_mem[i] = 16'h0;
        #3;
        chk("rst_dtack", 32'(dtack), 1);
        chk("rst_berr", 32'(berr), 1);
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
        chk("rst_a_dout", 32'({sram_a, sram_dout}), 0);
        chk("rst_lk", 32'({lk_ack, lk_data}), 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        // write then read
        cpu_acc(1, 8'h12, 16'hBEEF, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("wr_ack", 32'(ack), 1);
        chk("wr_we_cycles", 32'(wec), N);
        cpu_acc(0, 8'h12, 0, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("rd_ack", 32'(ack), 1);
        chk("rd_data", 32'(rdat), 32'(ref_mem[8'h12]));
        // byte write
        cpu_acc(1, 8'h12, 16'h5500, 1, 0, rdat, wec, ack, err, ce, lanes);
        chk("byte_lanes", 32'(lanes), 32'(2'b01));
        cpu_acc(0, 8'h12, 0, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("byte_rd", 32'(rdat), 32'(ref_mem[8'h12]));
        // lookup
        lookup(8'h12, lat, acks);
        chk("lk_latency", 32'(lat), N + 1);
        chk("lk_acks", 32'(acks), 1);
        chk("lk_data", 32'(lk_data), 32'(ref_mem[8'h12]));
        held = lk_data;
        cpu_acc(1, 8'h12, 16'h1234, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("lk_data_held", 32'(lk_data), 32'(held));
        // contention: first after a CPU grant, second after a lone lookup
        contest(8'h12, 8'h13);
        lookup(8'h13, lat, acks);
        chk("lk2_data", 32'(lk_data), 32'(ref_mem[8'h13]));
        contest(8'h12, 8'h13);
        // write protect
        wprot = 1;
        cpu_acc(1, 8'h20, 16'hDEAD, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("wp_berr", 32'(err), 1);
        chk("wp_no_dtack", 32'(ack), 0);
        chk("wp_no_ce", 32'(ce), 0);
        wprot = 0;
        cpu_acc(0, 8'h20, 0, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("wp_unchanged", 32'(rdat), 32'(ref_mem[8'h20]));
        // randomized write/read traffic
        for (int k = 0; k < 10; k++) begin
            logic [7:0] a;
            logic [15:0] wd;
            int ln;
            a = 8'h40 + 8'($urandom_range(0, 15));
            wd = 16'($urandom);
            ln = $urandom_range(0, 2);
            cpu_acc(1, a, wd, ln[0], ln[1], rdat, wec, ack, err, ce, lanes);
            chk("rnd_wr_ack", 32'(ack), 1);
            chk("rnd_we_cycles", 32'(wec), N);
            a = 8'h40 + 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                lookup(a, lat, acks);
                chk("rnd_lk", 32'(lk_data), 32'(ref_mem[a]));
            end else begin
                cpu_acc(0, a, 0, 0, 0, rdat, wec, ack, err, ce, lanes);
                chk("rnd_rd", 32'(rdat), 32'(ref_mem[a]));
            end
        end
        // abort: enable drops while the write strobe is low
        enable = 1; addr = 8'h30; write = 1; lds = 0; uds = 0; d_drv = 16'hA5C3; d_en = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = !sram_we_n; end
        chk("abort_we_seen", 32'(seen), 1);
        enable = 0;
        ack = 0;
        repeat (8) begin @(negedge clk); if (!dtack) ack = 1; end
        lds = 1; uds = 1; d_en = 0;
        chk("abort_no_dtack", 32'(ack), 0);
        chk("abort_idle", 32'({sram_ce_n, dtack, berr}), 32'h7);
        ref_write(8'h30, 16'hA5C3, 0, 0);
        cpu_acc(0, 8'h30, 0, 0, 0, rdat, wec, ack, err, ce, lanes);
        chk("abort_written", 32'(rdat), 32'(ref_mem[8'h30]));
        // async reset during a lookup
        lk_req = 1; lk_idx = 8'h30; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = !sram_oe_n; end
        chk("rst_lk_started", 32'(seen), 1);
        reset_n = 0;
        #1;
        chk("arst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
        chk("arst_a_dout", 32'({sram_a, sram_dout}), 0);
        chk("arst_lk", 32'({lk_ack, lk_data}), 0);
        chk("arst_bus", 32'({dtack, berr}), 32'h3);
        lk_req = 0;
        @(negedge clk);
        reset_n = 1;
        acks = 0;
        repeat (6) begin @(negedge clk); if (lk_ack) acks++; end
        chk("arst_no_ack", 32'(acks), 0);
        chk("oe_we_exclusive", 32'(clash), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pgtbl_ctrl.md
Name: pgtbl_ctrl

Overview:
- Memory controller for the 256-entry x 16-bit page table SRAM.
- Shares the single SRAM between two requesters: 68000 bus accesses (supervisor configures page table entries) and MMU translation lookups.
- Sequences the SRAM control strobes with a configurable number of wait states and generates 68000 DTACK/BERR.
- Sits in the glue logic between the CPU address decoder, the MMU translation path and the external asynchronous SRAM.

Parameters:
SRAM_WAIT, 1, extra clk cycles each SRAM read or write strobe is held beyond the first; range 0-7.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  CPU cycle targets the page table (from address decode); held high for the whole bus cycle
addr  in  8  CPU word address (entry index)
lds  in  1  lower data strobe, active low, covers d[7:0]
uds  in  1  upper data strobe, active low, covers d[15:8]
write  in  1  1 = CPU write, 0 = CPU read
d  inout  16  CPU data bus; driven only in CPU_DONE of a read, high-Z otherwise
wprot  in  1  1 = page table write-protected; CPU writes are rejected
dtack  out  1  active-low data acknowledge
berr  out  1  active-low bus error
lk_req  in  1  MMU lookup request; level, held until lk_ack
lk_idx  in  8  entry index for the lookup; sampled on grant
lk_ack  out  1  one-cycle pulse; lk_data valid from this cycle onward
lk_data  out  16  last looked-up entry; held until the next lk_ack
sram_a  out  8  SRAM address
sram_din  in  16  SRAM read data
sram_dout  out  16  SRAM write data
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM chip enable, output enable and write enable, active low
sram_lb_n, sram_ub_n  out  1 each  SRAM byte lane enables, active low

Behaviour:
- Reset values:
  - dtack=1, berr=1, d high-Z.
  - All sram_*_n=1, sram_a=0, sram_dout=0.
  - lk_ack=0, lk_data=0, state IDLE, prio=0.
- CPU request in IDLE: enable=1 and (lds=0 or uds=0). A lookup request in IDLE: lk_req=1.
- Arbitration in IDLE:
  - Only one requester pending: that requester is granted.
  - Both pending: prio=0 grants the lookup; prio=1 grants the CPU.
  - A lookup grant sets prio=1; a CPU grant clears prio.
  - A granted access runs to completion; there is no preemption.
- Access length: N = SRAM_WAIT+1 cycles with the strobe asserted.
- States:
  - LK_RD: sram_a=captured lk_idx; ce_n, oe_n, lb_n, ub_n all 0; lasts N cycles. On the last cycle capture sram_din into lk_data. On the next cycle go to IDLE and pulse lk_ack=1. Latency from grant to lk_ack is N+1 cycles.
  - CPU_RD: sram_a=addr; ce_n, oe_n, lb_n, ub_n all 0 (full word regardless of strobes); lasts N cycles. On the last cycle capture sram_din into a read register, then go to CPU_DONE.
  - CPU_WR_SU (1 cycle): ce_n=0, we_n=1, sram_a=addr, sram_dout=d, lb_n=lds, ub_n=uds.
  - CPU_WR (N cycles): as CPU_WR_SU but we_n=0.
  - CPU_WR_HD (1 cycle): we_n=1, with address, data and lane enables unchanged; then go to CPU_DONE.
  - CPU_DONE: dtack=0. On a read, d is driven with the read register. Stay until enable=0, then go to IDLE; dtack=1 and d high-Z take effect in the cycle enable is seen low.
  - CPU_ERR: entered from IDLE when a CPU write is requested with wprot=1. berr=0, dtack=1, no SRAM access. Stay until enable=0, then go to IDLE. This does not count as a grant; prio is unchanged.
- Rules that apply in every state:
  - sram_oe_n=0 and sram_we_n=0 are never asserted together.
  - sram_ce_n=1 in IDLE, CPU_DONE and CPU_ERR.
- enable drops mid-access: the SRAM access (read or write sequence) completes. CPU_DONE is skipped and the block returns to IDLE without asserting dtack.
- lk_req dropping before grant is ignored; no lk_ack is issued.
- Strobes low with enable=0: no CPU request.
- Async reset mid-operation: all outputs go to reset values immediately, and a write in progress is abandoned.
- Back-to-back: a new request can be granted in the cycle after the block returns to IDLE.

Test Plan:
- CPU write then read, SRAM_WAIT=1: write addr=0x12, d=0xBEEF, lds=uds=0. Required: we_n low 2 cycles, dtack=0 until enable drops. A read of 0x12 returns d=0xBEEF with dtack=0.
- Byte write: entry 0x12 holds 0xBEEF; write addr=0x12, d=0x5500, uds=0, lds=1. Required: ub_n=0, lb_n=1 during the write. A following read returns 0x55EF.
- Lookup: lk_req=1, lk_idx=0x12. Required: lk_ack pulses exactly once, 3 cycles after grant (SRAM_WAIT=1). lk_data=0x55EF and is held until the next lookup.
- Contention: lk_req and a CPU read asserted in the same cycle, twice in a row. Required: first contest grants the lookup, second contest grants the CPU. Bench checks oe_n/we_n never low together.
- Write protect: wprot=1, write addr=0x20. Required: berr=0, dtack=1, sram_ce_n stays 1, SRAM contents unchanged. berr returns to 1 when enable drops.
- Abort and reset: enable dropped during CPU_WR. Required: the write completes, dtack stays 1, state is IDLE. Then reset_n pulsed low during LK_RD. Required: all outputs at reset values, no lk_ack issued.
